// File: rtl/gate_pkg.sv
// Shared types and widths for the parking gate access sequencer.
package gate_pkg;

    localparam int TMR_W = 8;
    localparam int OCC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK_PW   = 3'd1,
        ST_OPEN_IN    = 3'd2,
        ST_OPEN_OUT   = 3'd3,
        ST_WAIT_CLEAR = 3'd4,
        ST_BLOCKED    = 3'd5
    } gate_state_e;

    // Occupancy step that clamps at 0 and cap instead of wrapping.
    function automatic logic [OCC_W-1:0] occ_adjust(
        input logic [OCC_W-1:0] occ,
        input logic             inc,
        input logic             dec,
        input logic [OCC_W-1:0] cap
    );
        logic [OCC_W-1:0] res;
        if (inc) begin
            res = (occ < cap) ? occ + OCC_W'(1) : occ;
        end else if (dec) begin
            res = (occ != {OCC_W{1'b0}}) ? occ - OCC_W'(1) : occ;
        end else begin
            res = occ;
        end
        return res;
    endfunction

endpackage

// File: rtl/gate_tick_timer.sv
// Loadable down-counter advanced only by the timebase tick; o_zero flags expiry.
module gate_tick_timer
    import gate_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    // Load wins over the tick so a freshly entered state always gets its full window.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= {TMR_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != {TMR_W{1'b0}})) begin
            r_count <= r_count - TMR_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {TMR_W{1'b0}});

endmodule

// File: rtl/gate_access_sequencer.sv
// Parking barrier sequencer: entry password check, occupancy, lockout.
// Optional GATE_ROUND_ROBIN_EN: least-recently-served lane wins when both request.
module gate_access_sequencer
    import gate_pkg::*;
#(
    parameter int unsigned CAPACITY   = 4,
    parameter int unsigned MAX_TRIES  = 3,
    parameter int unsigned PW_TICKS   = 20,
    parameter int unsigned GATE_TICKS = 10,
    parameter int unsigned LOCK_TICKS = 30
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             tick,
    input  logic             SE,
    input  logic             SS,
    input  logic             pass,
    input  logic             pw_valid,
    input  logic             pw_ok,
    output logic             Liberado,
    output logic             Saida,
    output logic             Pare,
    output logic             Bloqueado,
    output logic             Full,
    output logic [OCC_W-1:0] occupancy,
    output logic [2:0]       state
);

    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    gate_state_e      r_state;
    logic [OCC_W-1:0] r_occ;
    logic [2:0]       r_fail;
    logic             r_served_exit;
    logic             r_liberado;
    logic             r_saida;
    logic             r_pare;
    logic             r_bloqueado;
    logic             r_full;

    gate_state_e      w_next_state;
    logic [OCC_W-1:0] w_occ_next;
    logic [2:0]       w_fail_next;
    logic             w_served_exit_next;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic             w_exit_ok;
    logic             w_entry_ok;
    logic             w_pick_exit;
    logic [3:0]       w_fail_inc;

    assign w_exit_ok  = SS && (r_occ != {OCC_W{1'b0}});
    assign w_entry_ok = SE && !r_full;
    assign w_fail_inc = {1'b0, r_fail} + 4'd1;

`ifdef GATE_ROUND_ROBIN_EN
    assign w_pick_exit = w_exit_ok && !(w_entry_ok && r_served_exit);
`else
    assign w_pick_exit = w_exit_ok;
`endif

    gate_tick_timer u_timer (
        .i_clk      (CLK),
        .i_reset    (reset),
        .i_tick     (tick),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Next-state, timer load and bookkeeping decisions.
    always_comb begin
        w_next_state       = r_state;
        w_occ_next         = r_occ;
        w_fail_next        = r_fail;
        w_served_exit_next = r_served_exit;
        w_tmr_load         = 1'b0;
        w_tmr_val          = {TMR_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_pick_exit) begin
                    w_next_state       = ST_OPEN_OUT;
                    w_tmr_load         = 1'b1;
                    w_tmr_val          = TMR_W'(GATE_TICKS);
                    w_served_exit_next = 1'b1;
                end else if (w_entry_ok) begin
                    w_next_state       = ST_CHECK_PW;
                    w_tmr_load         = 1'b1;
                    w_tmr_val          = TMR_W'(PW_TICKS);
                    w_served_exit_next = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK_PW: begin
                if (pw_valid && pw_ok) begin
                    w_next_state = ST_OPEN_IN;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TMR_W'(GATE_TICKS);
                    w_fail_next  = 3'd0;
                end else if (pw_valid) begin
                    if (w_fail_inc == 4'(MAX_TRIES)) begin
                        w_next_state = ST_BLOCKED;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TMR_W'(LOCK_TICKS);
                        w_fail_next  = 3'd0;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_fail_next  = w_fail_inc[2:0];
                    end
                end else if (w_tmr_zero) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_CHECK_PW;
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                if (pass) begin
                    w_occ_next   = occ_adjust(r_occ, r_state == ST_OPEN_IN,
                                              r_state == ST_OPEN_OUT, CAP_V);
                    w_next_state = ST_WAIT_CLEAR;
                end else if (w_tmr_zero) begin
                    w_next_state = ST_WAIT_CLEAR;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_WAIT_CLEAR: begin
                // Only the lane just served must clear; the other lane waits its turn.
                if (r_served_exit ? !SS : !SE) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_CLEAR;
                end
            end
            ST_BLOCKED: begin
                if (w_tmr_zero) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_BLOCKED;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_occ         <= {OCC_W{1'b0}};
            r_fail        <= 3'd0;
            r_served_exit <= 1'b1;
            r_liberado    <= 1'b0;
            r_saida       <= 1'b0;
            r_pare        <= 1'b1;
            r_bloqueado   <= 1'b0;
            r_full        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_occ         <= w_occ_next;
            r_fail        <= w_fail_next;
            r_served_exit <= w_served_exit_next;
            r_liberado    <= (w_next_state == ST_OPEN_IN);
            r_saida       <= (w_next_state == ST_OPEN_OUT);
            r_pare        <= !((w_next_state == ST_OPEN_IN) || (w_next_state == ST_OPEN_OUT));
            r_bloqueado   <= (w_next_state == ST_BLOCKED);
            r_full        <= (w_occ_next == CAP_V);
        end
    end

    assign Liberado  = r_liberado;
    assign Saida     = r_saida;
    assign Pare      = r_pare;
    assign Bloqueado = r_bloqueado;
    assign Full      = r_full;
    assign occupancy = r_occ;
    assign state     = r_state;

endmodule

// File: tb/tb_gate_access_sequencer.sv
// Directed self-checking bench for gate_access_sequencer (default parameters).
module tb_gate_access_sequencer;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       SE = 1'b0;
    logic       SS = 1'b0;
    logic       pass = 1'b0;
    logic       pw_valid = 1'b0;
    logic       pw_ok = 1'b0;
    logic       Liberado, Saida, Pare, Bloqueado, Full;
    logic [7:0] occupancy;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    gate_access_sequencer dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick      (tick),
        .SE        (SE),
        .SS        (SS),
        .pass      (pass),
        .pw_valid  (pw_valid),
        .pw_ok     (pw_ok),
        .Liberado  (Liberado),
        .Saida     (Saida),
        .Pare      (Pare),
        .Bloqueado (Bloqueado),
        .Full      (Full),
        .occupancy (occupancy),
        .state     (state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic clkn(input int n);
        for (int k = 0; k < n; k++) clk1();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pw_pulse(input logic ok);
        pw_valid = 1'b1;
        pw_ok    = ok;
        clk1();
        pw_valid = 1'b0;
        pw_ok    = 1'b0;
    endtask

    task automatic pass_pulse();
        pass = 1'b1;
        clk1();
        pass = 1'b0;
    endtask

    task automatic enter_one();
        SE = 1'b1;
        clk1();
        pw_pulse(1'b1);
        pass_pulse();
        SE = 1'b0;
        clk1();
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_lib", Liberado, 0);
        chk("rst_saida", Saida, 0);
        chk("rst_pare", Pare, 1);
        chk("rst_bloq", Bloqueado, 0);
        chk("rst_full", Full, 0);

        // Normal entry with correct password
        SE = 1'b1;
        clk1();
        chk("e1_check", state, 1);
        chk("e1_pare_chk", Pare, 1);
        tick = 1'b1;
        clkn(2);
        pw_pulse(1'b1);
        chk("e1_open", state, 2);
        chk("e1_lib", Liberado, 1);
        chk("e1_pare_open", Pare, 0);
        clk1();
        chk("e1_lib_hold", Liberado, 1);
        pass_pulse();
        chk("e1_occ", occupancy, 1);
        chk("e1_wait", state, 4);
        chk("e1_lib_off", Liberado, 0);
        clk1();
        chk("e1_wait_se", state, 4);
        SE = 1'b0;
        clk1();
        chk("e1_idle", state, 0);
        chk("e1_pare", Pare, 1);

        // Three wrong passwords lead to lockout
        tick = 1'b0;
        SE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk1();
            pw_pulse(1'b0);
            if (i < 2) chk("wp_idle", state, 0);
        end
        chk("wp_blocked", state, 5);
        chk("wp_bloq", Bloqueado, 1);
        pass_pulse();
        pw_pulse(1'b1);
        clkn(2);
        chk("blk_ignore_state", state, 5);
        chk("blk_ignore_occ", occupancy, 1);
        tick = 1'b1;
        clkn(30);
        chk("blk_hold30", state, 5);
        chk("blk_bloq30", Bloqueado, 1);
        clk1();
        chk("blk_exit", state, 0);
        chk("blk_bloq_off", Bloqueado, 0);
        clk1();
        chk("blk_reenter", state, 1);
        pw_pulse(1'b0);
        chk("blk_fail_cleared", state, 0);
        SE = 1'b0;
        tick = 1'b0;
        clk1();

        // Fill to capacity, full refuses entry, exit frees a slot
        for (int i = 0; i < 3; i++) enter_one();
        chk("full_occ", occupancy, 4);
        chk("full_flag", Full, 1);
        SE = 1'b1;
        clk1();
        chk("full_idle", state, 0);
        chk("full_pare", Pare, 1);
        SE = 1'b0;
        SS = 1'b1;
        clk1();
        chk("exit_open", state, 3);
        chk("exit_saida", Saida, 1);
        pass_pulse();
        chk("exit_occ", occupancy, 3);
        chk("exit_full", Full, 0);
        chk("exit_saida_off", Saida, 0);
        SS = 1'b0;
        clk1();
        pass_pulse();
        chk("idle_pass_ignored", occupancy, 3);

        // Simultaneous requests with occupancy 2
        SS = 1'b1;
        clk1();
        pass_pulse();
        SS = 1'b0;
        clk1();
        chk("pri_occ2", occupancy, 2);
        SE = 1'b1;
        SS = 1'b1;
        clk1();
`ifdef GATE_ROUND_ROBIN_EN
        chk("pri_winner", state, 1);
`else
        chk("pri_winner", state, 3);
`endif
        SE = 1'b0;
        SS = 1'b0;
        tick = 1'b1;
        clkn(25);
        chk("pri_settle", state, 0);
        chk("pri_occ_kept", occupancy, 2);

        // OPEN_IN timeout without pass
        tick = 1'b0;
        SE = 1'b1;
        clk1();
        chk("to_check", state, 1);
        pw_pulse(1'b1);
        tick = 1'b1;
        clkn(10);
        chk("to_open10", state, 2);
        clk1();
        chk("to_wait", state, 4);
        chk("to_occ", occupancy, 2);
        SE = 1'b0;
        clk1();
        chk("to_idle", state, 0);

        // Password arriving on the expiry cycle is accepted
        tick = 1'b0;
        SE = 1'b1;
        clk1();
        SE = 1'b0;
        tick = 1'b1;
        clkn(20);
        chk("exp_still_check", state, 1);
        tick = 1'b0;
        pw_pulse(1'b1);
        chk("exp_accept", state, 2);
        pass_pulse();
        chk("exp_occ", occupancy, 3);
        clk1();

        // Plain password timeout returns to idle
        SE = 1'b1;
        clk1();
        SE = 1'b0;
        tick = 1'b1;
        clkn(21);
        chk("pwto_idle", state, 0);

        // Reset in the middle of an exit
        tick = 1'b0;
        SS = 1'b1;
        clk1();
        chk("mr_open_out", state, 3);
        chk("mr_occ3", occupancy, 3);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        SS = 1'b0;
        chk("mr_state", state, 0);
        chk("mr_occ", occupancy, 0);
        chk("mr_saida", Saida, 0);
        chk("mr_pare", Pare, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
